// File: rtl/dezigzag.sv
// Zigzag-to-column-major reorder for 8x8 coefficient blocks, double-banked.
// Optional feature: DEZIGZAG_EOB_EN adds eob_in and per-bank written-masks for early block close.
module dezigzag #(
   parameter int W = 11
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         ena_in,
   output logic         rdy_out,
   input  logic [W-1:0] in,
`ifdef DEZIGZAG_EOB_EN
   input  logic         eob_in,
`endif
   input  logic         rdy_in,
   output logic         ena_out,
   output logic [W-1:0] out
);

   // Column-major address (c*8+r) for each zigzag position k.
   localparam logic [5:0] ZZ_ADDR [64] = '{
      6'd0,  6'd8,  6'd1,  6'd2,  6'd9,  6'd16, 6'd24, 6'd17,
      6'd10, 6'd3,  6'd4,  6'd11, 6'd18, 6'd25, 6'd32, 6'd40,
      6'd33, 6'd26, 6'd19, 6'd12, 6'd5,  6'd6,  6'd13, 6'd20,
      6'd27, 6'd34, 6'd41, 6'd48, 6'd56, 6'd49, 6'd42, 6'd35,
      6'd28, 6'd21, 6'd14, 6'd7,  6'd15, 6'd22, 6'd29, 6'd36,
      6'd43, 6'd50, 6'd57, 6'd58, 6'd51, 6'd44, 6'd37, 6'd30,
      6'd23, 6'd31, 6'd38, 6'd45, 6'd52, 6'd59, 6'd60, 6'd53,
      6'd46, 6'd39, 6'd47, 6'd54, 6'd61, 6'd62, 6'd55, 6'd63
   };

   logic [W-1:0] mem [128];
   logic         wr_bank;
   logic         rd_bank;
   logic [1:0]   full;
   logic [5:0]   wr_idx;
   logic [5:0]   rd_idx;
   logic [5:0]   wr_addr;
   logic         wr_fire;
   logic         wr_close;
   logic         rd_fire;
   logic         rd_last;
   logic [W-1:0] rd_data;

   assign rdy_out = !full[wr_bank];
   assign wr_fire = ena_in && rdy_out;
   assign wr_addr = ZZ_ADDR[wr_idx];
   assign rd_fire = rdy_in && full[rd_bank];
   assign rd_last = rd_fire && (rd_idx == 6'd63);

`ifdef DEZIGZAG_EOB_EN
   logic [63:0] wmask [2];

   // eob_in closes the block after any coincident write has landed.
   assign wr_close = (wr_fire && (wr_idx == 6'd63)) || (eob_in && rdy_out);
   assign rd_data  = wmask[rd_bank][rd_idx] ? mem[{rd_bank, rd_idx}] : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         wmask[0] <= '0;
         wmask[1] <= '0;
      end else begin
         if (wr_fire) wmask[wr_bank][wr_addr] <= 1'b1;
         if (rd_last) wmask[rd_bank] <= '0;
      end
   end
`else
   assign wr_close = wr_fire && (wr_idx == 6'd63);
   assign rd_data  = mem[{rd_bank, rd_idx}];
`endif

   always_ff @(posedge clk) begin
      if (wr_fire) mem[{wr_bank, wr_addr}] <= in;
   end

   // Write close and read free always target different banks, so both full updates are safe.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_bank <= 1'b0;
         rd_bank <= 1'b0;
         full    <= 2'b00;
         wr_idx  <= 6'd0;
         rd_idx  <= 6'd0;
      end else begin
         if (wr_close) begin
            full[wr_bank] <= 1'b1;
            wr_bank       <= ~wr_bank;
            wr_idx        <= 6'd0;
         end else if (wr_fire) begin
            wr_idx <= wr_idx + 6'd1;
         end
         if (rd_fire) begin
            rd_idx <= rd_idx + 6'd1;
            if (rd_last) begin
               full[rd_bank] <= 1'b0;
               rd_bank       <= ~rd_bank;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ena_out <= 1'b0;
         out     <= '0;
      end else begin
         ena_out <= rd_fire;
         if (rd_fire) out <= rd_data;
      end
   end

endmodule
